// File: rtl/polynomial_pkg.sv
// Shared float-word types for the polynomial tap loader and the downstream estimator.
package polynomial_pkg;

    localparam int C_FP_DWIDTH = 32;

    typedef logic [C_FP_DWIDTH-1:0] float_t;

endpackage

// File: rtl/polynomial_tap_loader_if.sv
// Coefficient stream into the tap loader: one float word per valid/ready beat, last marks set end.
interface polynomial_tap_loader_if;
    import polynomial_pkg::*;

    float_t coef_din;
    logic   coef_din_valid;
    logic   coef_din_last;
    logic   coef_din_ready;

    modport master (
        output coef_din,
        output coef_din_valid,
        output coef_din_last,
        input  coef_din_ready
    );

    modport slave (
        input  coef_din,
        input  coef_din_valid,
        input  coef_din_last,
        output coef_din_ready
    );

endinterface

// File: rtl/polynomial_tap_loader.sv
// Double-buffered polynomial tap store: a framed coefficient stream fills the shadow bank,
// which becomes the active (read) bank once the downstream estimator is idle.
module polynomial_tap_loader
    import polynomial_pkg::*;
#(
    parameter int G_POLY_ORDER = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    polynomial_tap_loader_if.slave        coef,
    input  logic                          consumer_busy,
    input  logic                          tap_rd_en,
    input  logic [7:0]                    tap_rd_addr,
    output float_t                        tap_rd_data,
    output logic                          tap_rd_valid,
    output logic                          taps_valid,
    output logic                          swap_pending,
    output logic                          load_error
);

    localparam int                 C_IDX_W    = $clog2(G_POLY_ORDER);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(G_POLY_ORDER - 1);
    localparam logic [7:0]         C_ORDER_8  = 8'(G_POLY_ORDER);

    typedef enum logic [1:0] {
        SM_INIT,
        SM_LOAD,
        SM_WAIT_SWAP,
        SM_SWAP
    } state_t;

    state_t               state;
    logic [C_IDX_W-1:0]   word_idx;
    logic                 bank_ptr;
    logic                 coef_ready_q;
    float_t               banks [2][G_POLY_ORDER];

    logic                 word_accept;
    logic                 at_last_idx;
    logic                 framing_bad;

    assign coef.coef_din_ready = coef_ready_q;
    assign word_accept         = coef.coef_din_valid & coef_ready_q;
    assign at_last_idx         = (word_idx == C_LAST_IDX);
    // A set is well framed only when last coincides exactly with the final tap slot.
    assign framing_bad         = (coef.coef_din_last != at_last_idx);

    // Control FSM plus both banks; outputs are registered alongside the state so they
    // change on the same edge as the transition that implies them.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state        <= SM_INIT;
            word_idx     <= '0;
            bank_ptr     <= 1'b0;
            coef_ready_q <= 1'b0;
            taps_valid   <= 1'b0;
            swap_pending <= 1'b0;
            load_error   <= 1'b0;
            // NOTE: the banks are small register arrays with a defined all-zero reset image, not RAM.
            banks        <= '{default: '0};
        end else begin
            load_error <= 1'b0;
            if (!enable) begin
                state        <= SM_INIT;
                word_idx     <= '0;
                coef_ready_q <= 1'b0;
                swap_pending <= 1'b0;
            end else begin
                case (state)
                    SM_INIT: begin
                        state        <= SM_LOAD;
                        coef_ready_q <= 1'b1;
                    end
                    SM_LOAD: begin
                        if (word_accept) begin
                            if (framing_bad) begin
                                load_error <= 1'b1;
                                word_idx   <= '0;
                            end else begin
                                banks[~bank_ptr][word_idx] <= coef.coef_din;
                                if (at_last_idx) begin
                                    word_idx     <= '0;
                                    state        <= SM_WAIT_SWAP;
                                    coef_ready_q <= 1'b0;
                                    swap_pending <= 1'b1;
                                end else begin
                                    word_idx <= word_idx + C_IDX_W'(1);
                                end
                            end
                        end
                    end
                    SM_WAIT_SWAP: begin
                        if (!consumer_busy) begin
                            state <= SM_SWAP;
                        end
                    end
                    SM_SWAP: begin
                        bank_ptr     <= ~bank_ptr;
                        taps_valid   <= 1'b1;
                        state        <= SM_LOAD;
                        coef_ready_q <= 1'b1;
                        swap_pending <= 1'b0;
                    end
                    default: begin
                        state        <= SM_INIT;
                        coef_ready_q <= 1'b0;
                        swap_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read port runs independently of the FSM and enable; bank_ptr is sampled pre-toggle,
    // so a read issued in the swap cycle still sees the old bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_rd_valid <= 1'b0;
            tap_rd_data  <= '0;
        end else begin
            tap_rd_valid <= tap_rd_en;
            if (tap_rd_en) begin
                tap_rd_data <= (tap_rd_addr < C_ORDER_8)
                             ? banks[bank_ptr][tap_rd_addr[C_IDX_W-1:0]]
                             : '0;
            end
        end
    end

endmodule

// File: tb/tb_polynomial_tap_loader.sv
// Randomized self-checking bench for polynomial_tap_loader against a set-level reference model.
module tb_polynomial_tap_loader;
    import polynomial_pkg::*;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       consumer_busy;
    logic       tap_rd_en;
    logic [7:0] tap_rd_addr;
    float_t     tap_rd_data;
    logic       tap_rd_valid;
    logic       taps_valid;
    logic       swap_pending;
    logic       load_error;

    polynomial_tap_loader_if coef_bus ();

    polynomial_tap_loader #(.G_POLY_ORDER(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .coef          (coef_bus),
        .consumer_busy (consumer_busy),
        .tap_rd_en     (tap_rd_en),
        .tap_rd_addr   (tap_rd_addr),
        .tap_rd_data   (tap_rd_data),
        .tap_rd_valid  (tap_rd_valid),
        .taps_valid    (taps_valid),
        .swap_pending  (swap_pending),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    int     n_tests    = 0;
    int     n_fail     = 0;
    int     err_pulses = 0;
    float_t model_active [N];
    logic   model_valid;

    always @(negedge clk) if (load_error === 1'b1) err_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rand_set(output float_t w [N]);
        for (int i = 0; i < N; i++) w[i] = $urandom;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic push_word(input float_t d, input logic last);
        int waited = 0;
        coef_bus.coef_din       = d;
        coef_bus.coef_din_last  = last;
        coef_bus.coef_din_valid = 1'b1;
        while (coef_bus.coef_din_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        coef_bus.coef_din_valid = 1'b0;
        coef_bus.coef_din_last  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input float_t exp);
        tap_rd_en   = 1'b1;
        tap_rd_addr = addr;
        @(negedge clk);
        tap_rd_en = 1'b0;
        check({tag, "_valid"}, 32'(tap_rd_valid), 32'd1);
        check({tag, "_data"}, tap_rd_data, exp);
    endtask

    task automatic check_bank(input string tag);
        for (int a = 0; a < N; a++) read_check(tag, 8'(a), model_active[a]);
    endtask

    task automatic load_and_commit(input float_t w [N], input int busy_hold);
        int waited = 0;
        consumer_busy = (busy_hold > 0);
        for (int i = 0; i < N; i++) push_word(w[i], i == N - 1);
        check("commit_pending", 32'(swap_pending), 32'd1);
        check("commit_ready_low", 32'(coef_bus.coef_din_ready), 32'd0);
        repeat (busy_hold) @(negedge clk);
        if (busy_hold > 0) check("busy_still_pending", 32'(swap_pending), 32'd1);
        consumer_busy = 1'b0;
        while (swap_pending === 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("swap_done", 32'(swap_pending), 32'd0);
        model_active = w;
        model_valid  = 1'b1;
        check("commit_taps_valid", 32'(taps_valid), 32'(model_valid));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        float_t w [N];
        float_t old [N];
        float_t held;
        int     e0;
        int     a;

        reset                   = 1'b1;
        enable                  = 1'b1;
        consumer_busy           = 1'b0;
        tap_rd_en               = 1'b0;
        tap_rd_addr             = '0;
        coef_bus.coef_din       = '0;
        coef_bus.coef_din_valid = 1'b0;
        coef_bus.coef_din_last  = 1'b0;
        model_active            = '{default: '0};
        model_valid             = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(coef_bus.coef_din_ready), 32'd0);
        check("rst_rd_valid", 32'(tap_rd_valid), 32'd0);
        check("rst_rd_data", tap_rd_data, 32'd0);
        check("rst_taps_valid", 32'(taps_valid), 32'd0);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        reset = 1'b0;

        // Early last on the 3rd word.
        rand_set(w);
        e0 = err_pulses;
        push_word(w[0], 1'b0);
        push_word(w[1], 1'b0);
        push_word(w[2], 1'b1);
        check("early_last_err", 32'(load_error), 32'd1);
        @(negedge clk);
        check("early_last_err_1cyc", 32'(load_error), 32'd0);
        check("early_last_pulses", 32'(err_pulses - e0), 32'd1);
        check("early_last_taps_valid", 32'(taps_valid), 32'd0);

        // Missing last on the final word.
        e0 = err_pulses;
        for (int i = 0; i < N; i++) push_word(w[i], 1'b0);
        @(negedge clk);
        check("late_last_pulses", 32'(err_pulses - e0), 32'd1);
        check("late_last_pending", 32'(swap_pending), 32'd0);

        // Clean load with exact swap timing.
        w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        for (int i = 0; i < N; i++) push_word(w[i], i == N - 1);
        check("clean_pending_t0", 32'(swap_pending), 32'd1);
        check("clean_taps_t0", 32'(taps_valid), 32'd0);
        @(negedge clk);
        check("clean_pending_t1", 32'(swap_pending), 32'd1);
        check("clean_taps_t1", 32'(taps_valid), 32'd0);
        @(negedge clk);
        check("clean_taps_t2", 32'(taps_valid), 32'd1);
        check("clean_pending_t2", 32'(swap_pending), 32'd0);
        model_active = w;
        model_valid  = 1'b1;
        read_check("clean_addr2", 8'd2, 32'h40400000);
        check_bank("clean_bank");

        // Out-of-range reads and read-data hold.
        read_check("oor_7", 8'd7, 32'd0);
        read_check("oor_rand", 8'($urandom_range(255, N)), 32'd0);
        read_check("hold_src", 8'd1, model_active[1]);
        held = model_active[1];
        repeat (3) begin
            tap_rd_addr = 8'($urandom_range(0, N - 1));
            @(negedge clk);
            check("hold_data", tap_rd_data, held);
            check("hold_valid", 32'(tap_rd_valid), 32'd0);
        end

        // Deferred swap while the consumer is busy.
        old = model_active;
        rand_set(w);
        consumer_busy = 1'b1;
        for (int i = 0; i < N; i++) push_word(w[i], i == N - 1);
        repeat (3) begin
            check("defer_pending", 32'(swap_pending), 32'd1);
            check("defer_ready", 32'(coef_bus.coef_din_ready), 32'd0);
            a = $urandom_range(0, N - 1);
            read_check("defer_old_read", 8'(a), old[a]);
        end
        consumer_busy = 1'b0;
        @(negedge clk);
        check("defer_swap_cycle_pending", 32'(swap_pending), 32'd1);
        a = $urandom_range(0, N - 1);
        read_check("defer_swap_cycle_read", 8'(a), old[a]);
        check("defer_after_pending", 32'(swap_pending), 32'd0);
        check("defer_after_ready", 32'(coef_bus.coef_din_ready), 32'd1);
        model_active = w;
        check_bank("defer_new_bank");

        // Abort a partial set by dropping enable.
        rand_set(w);
        e0 = err_pulses;
        push_word(w[0], 1'b0);
        push_word(w[1], 1'b0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready", 32'(coef_bus.coef_din_ready), 32'd0);
        check("abort_taps_valid", 32'(taps_valid), 32'd1);
        check("abort_pending", 32'(swap_pending), 32'd0);
        check_bank("abort_old_bank");
        enable = 1'b1;
        rand_set(w);
        load_and_commit(w, 0);
        check("abort_no_err", 32'(err_pulses - e0), 32'd0);
        check_bank("abort_reload_bank");

        // Randomized sets with random busy hold and occasional framing errors.
        for (int it = 0; it < 15; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                int k = $urandom_range(0, N - 2);
                e0 = err_pulses;
                for (int i = 0; i < k; i++) push_word($urandom, 1'b0);
                push_word($urandom, 1'b1);
                @(negedge clk);
                check("rand_err_pulses", 32'(err_pulses - e0), 32'd1);
                check("rand_err_taps_valid", 32'(taps_valid), 32'(model_valid));
            end
            rand_set(w);
            load_and_commit(w, $urandom_range(0, 3));
            repeat (3) begin
                a = $urandom_range(0, N + 2);
                read_check("rand_read", 8'(a), (a < N) ? model_active[a] : 32'd0);
            end
        end

        // Reset in the middle of word 3.
        rand_set(w);
        push_word(w[0], 1'b0);
        push_word(w[1], 1'b0);
        coef_bus.coef_din       = w[2];
        coef_bus.coef_din_valid = 1'b1;
        reset                   = 1'b1;
        @(negedge clk);
        coef_bus.coef_din_valid = 1'b0;
        check("mid_rst_ready", 32'(coef_bus.coef_din_ready), 32'd0);
        check("mid_rst_rd_valid", 32'(tap_rd_valid), 32'd0);
        check("mid_rst_rd_data", tap_rd_data, 32'd0);
        check("mid_rst_taps_valid", 32'(taps_valid), 32'd0);
        check("mid_rst_pending", 32'(swap_pending), 32'd0);
        check("mid_rst_load_error", 32'(load_error), 32'd0);
        reset        = 1'b0;
        model_active = '{default: '0};
        model_valid  = 1'b0;
        read_check("mid_rst_addr0", 8'd0, 32'd0);
        check_bank("mid_rst_bank");
        rand_set(w);
        load_and_commit(w, 1);
        check_bank("post_rst_bank");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/polynomial_tap_loader.md
POLYNOMIAL_TAP_LOADER -- requirements
Module: polynomial_tap_loader

Interface
REQ-001 SHALL have parameter G_POLY_ORDER, default 5: number of 32-bit float taps per set, legal range 2..255.
REQ-002 SHALL have localparam C_FP_DWIDTH, fixed 32: float word width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  0 = hold the state machine in SM_INIT.
REQ-006 coef_din  in  32  incoming tap word, tap 0 first.
REQ-007 coef_din_valid  in  1  coef_din qualifier.
REQ-008 coef_din_last  in  1  marks the final word of a tap set.
REQ-009 coef_din_ready  out  1  loader accepts a word when valid and ready are both 1.
REQ-010 consumer_busy  in  1  1 = downstream estimator is mid-evaluation; no bank swap allowed.
REQ-011 tap_rd_en  in  1  tap read request.
REQ-012 tap_rd_addr  in  8  tap index to read.
REQ-013 tap_rd_data  out  32  active-bank tap value.
REQ-014 tap_rd_valid  out  1  tap_rd_data qualifier.
REQ-015 taps_valid  out  1  active bank holds a complete committed set.
REQ-016 swap_pending  out  1  a complete set is waiting for consumer_busy to be 0.
REQ-017 load_error  out  1  one-cycle pulse on a framing error.

Function
REQ-018 SHALL hold two banks of G_POLY_ORDER words: active (read side) and shadow (write side), selected by a 1-bit bank pointer.
REQ-019 States: SM_INIT, SM_LOAD, SM_WAIT_SWAP, SM_SWAP.
  - SM_INIT -> SM_LOAD after one cycle.
  - SM_LOAD -> SM_WAIT_SWAP on a valid final word.
  - SM_WAIT_SWAP -> SM_SWAP when consumer_busy = 0.
  - SM_SWAP -> SM_LOAD after one cycle.
REQ-020 coef_din_ready SHALL be 1 only in SM_LOAD.
REQ-021 In SM_LOAD, each accepted word SHALL be written to shadow[word_idx]; word_idx then increments.
REQ-022 When word_idx = G_POLY_ORDER-1 and coef_din_last = 1, the write SHALL occur, word_idx SHALL clear, and the state SHALL go to SM_WAIT_SWAP.
REQ-023 Framing error: coef_din_last = 1 with word_idx < G_POLY_ORDER-1, or coef_din_last = 0 with word_idx = G_POLY_ORDER-1.
  - load_error pulses for 1 cycle.
  - word_idx clears; the partial set is discarded.
  - The state stays SM_LOAD; the active bank is untouched.
REQ-024 swap_pending SHALL be 1 throughout SM_WAIT_SWAP and SM_SWAP, and 0 otherwise.
REQ-025 SM_SWAP SHALL toggle the bank pointer and set taps_valid = 1 in the same cycle.
  - A read sampled in that cycle still returns the old bank.
REQ-026 If consumer_busy is 0 on the cycle the state enters SM_WAIT_SWAP, the swap SHALL occur on the next cycle.
  - Minimum final-word-accept to new-bank-visible latency: 2 cycles.
REQ-027 Read port latency SHALL be exactly 1 cycle.
  - tap_rd_valid(t+1) = tap_rd_en(t).
  - tap_rd_data(t+1) = active[tap_rd_addr(t)].
  - Reads are served in every state, including during load and swap.
REQ-028 tap_rd_addr >= G_POLY_ORDER SHALL return tap_rd_data = 0 with tap_rd_valid = 1.
REQ-029 When tap_rd_en = 0, tap_rd_data SHALL hold its previous value.
REQ-030 enable = 0 SHALL force SM_INIT and clear word_idx.
  - A partial load or a pending swap is discarded.
  - Both banks, the bank pointer and taps_valid are retained.
  - The read port stays functional.

Reset
REQ-031 reset SHALL take priority over enable.
REQ-032 On reset:
  - state = SM_INIT, word_idx = 0, bank pointer = 0.
  - Both banks all-zero.
  - coef_din_ready = 0, tap_rd_valid = 0, tap_rd_data = 0.
  - taps_valid = 0, swap_pending = 0, load_error = 0.
REQ-033 Reset mid-load or mid-swap SHALL abandon the operation; no shadow contents become active.

Structure
REQ-034 float_t (32-bit logic) and C_FP_DWIDTH SHALL live in the shared package polynomial_pkg, also used by the estimator.
REQ-035 state_t SHALL be local to the module.
REQ-036 No sub-module; the banks are inline register arrays.

Verification
REQ-037 Clean load, G_POLY_ORDER=5, consumer_busy=0: send words 0x3F800000..0x40A00000, last on the 5th.
  - swap_pending rises, then taps_valid = 1 two cycles after the last accept.
  - Reading addr 2 returns 0x40400000 one cycle later.
REQ-038 Early last: set last on the 3rd word.
  - load_error pulses once; taps_valid stays 0.
  - A following clean 5-word set commits normally.
REQ-039 Deferred swap: hold consumer_busy=1 through the final word.
  - The state stays SM_WAIT_SWAP; coef_din_ready = 0; reads return the old set.
  - Release busy: the swap occurs in 1 cycle; the new set is readable.
REQ-040 Out-of-range read: tap_rd_addr = 7 with tap_rd_en = 1.
  - tap_rd_data = 0 and tap_rd_valid = 1 next cycle.
REQ-041 Abort: drop enable low after 2 words of a second set.
  - The active (first) set is still readable; taps_valid stays 1.
  - After re-enable, a full set loads starting from word 0.
REQ-042 Reset mid-load: assert reset during word 3.
  - All outputs return to the REQ-032 values.
  - Reading addr 0 returns 0x00000000.
